// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester round-robin write-port arbiter for a register bank (optional ZERO_REG_GUARD_EN)
module regfile_write_arbiter #(
    parameter int WIDTH  = 32,
    parameter int AWIDTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req0,
    input  logic [AWIDTH-1:0]        addr0,
    input  logic [WIDTH-1:0]         data0,
    output logic                     gnt0,
    input  logic                     req1,
    input  logic [AWIDTH-1:0]        addr1,
    input  logic [WIDTH-1:0]         data1,
    output logic                     gnt1,
    output logic                     wen,
    output logic [AWIDTH-1:0]        waddr,
    output logic [WIDTH-1:0]         wdata,
    output logic [(1<<AWIDTH)-1:0]   wdec,
    output logic [7:0]               collisions
);
    localparam int NREG = 1 << AWIDTH;

    // Tie-break priority: which requester wins when both ask in the same cycle.
    typedef enum logic {
        PRI_REQ0 = 1'b0,
        PRI_REQ1 = 1'b1
    } pri_t;

    pri_t               ptr;
    pri_t               ptr_next;
    logic               hs;
    logic               do_write;
    logic [AWIDTH-1:0]  sel_addr;
    logic [WIDTH-1:0]   sel_data;
    logic [NREG-1:0]    dec_next;
    logic               contended;

    // Zero-latency grants; nothing is granted while reset is held.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            gnt0 = req0 & (~req1 | (ptr == PRI_REQ0));
            gnt1 = req1 & (~req0 | (ptr == PRI_REQ1));
        end
    end

    // Winner mux, pointer advance and write qualification for the coming edge.
    always_comb begin
        hs        = gnt0 | gnt1;
        contended = req0 & req1;
        sel_addr  = gnt1 ? addr1 : addr0;
        sel_data  = gnt1 ? data1 : data0;
        ptr_next  = ptr;
        if (gnt0) begin
            ptr_next = PRI_REQ1;
        end else if (gnt1) begin
            ptr_next = PRI_REQ0;
        end
`ifdef ZERO_REG_GUARD_EN
        // Register 0 is hardwired: grant and rotate, but never strobe it.
        do_write = hs & (sel_addr != '0);
`else
        do_write = hs;
`endif
        dec_next = '0;
        if (do_write) begin
            dec_next[sel_addr] = 1'b1;
        end
    end

    // Priority pointer moves to the loser after every grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= PRI_REQ0;
        end else begin
            ptr <= ptr_next;
        end
    end

    // Registered write port; address and data hold when nothing is granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wen   <= 1'b0;
            waddr <= '0;
            wdata <= '0;
            wdec  <= '0;
        end else begin
            wen  <= do_write;
            wdec <= dec_next;
            if (hs) begin
                waddr <= sel_addr;
                wdata <= sel_data;
            end
        end
    end

    // Saturating contention counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collisions <= 8'd0;
        end else if (contended && (collisions != 8'hFF)) begin
            collisions <= collisions + 8'd1;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;
    localparam int WIDTH  = 32;
    localparam int AWIDTH = 5;
    localparam int NREG   = 32;
`ifdef ZERO_REG_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              req0, req1;
    logic [AWIDTH-1:0] addr0, addr1;
    logic [WIDTH-1:0]  data0, data1;
    logic              gnt0, gnt1;
    logic              wen;
    logic [AWIDTH-1:0] waddr;
    logic [WIDTH-1:0]  wdata;
    logic [NREG-1:0]   wdec;
    logic [7:0]        collisions;

    regfile_write_arbiter #(.WIDTH(WIDTH), .AWIDTH(AWIDTH)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .wen(wen), .waddr(waddr), .wdata(wdata), .wdec(wdec),
        .collisions(collisions)
    );

    always #5 clk = ~clk;

    // Bank of registers fed by the write port.
    logic [WIDTH-1:0] bank [NREG];
    always @(posedge clk) begin
        if (!reset && wen) bank[waddr] <= wdata;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [NREG-1:0] onehot(input int a, input bit en);
        logic [NREG-1:0] v;
        v = '0;
        if (en) v[a] = 1'b1;
        return v;
    endfunction

    // Reference model: "the requester that did not win last gets the tie".
    int               m_pref;
    int               m_coll;
    bit               m_wen;
    int               m_waddr;
    logic [WIDTH-1:0] m_wdata;
    int               m_winner;

    task automatic model_reset();
        m_pref = 0; m_coll = 0; m_wen = 0; m_waddr = 0; m_wdata = '0; m_winner = -1;
    endtask

    task automatic model_edge();
        if (req0 && req1) m_winner = m_pref;
        else if (req0)    m_winner = 0;
        else if (req1)    m_winner = 1;
        else              m_winner = -1;
        if (req0 && req1) m_coll = (m_coll < 255) ? m_coll + 1 : 255;
        if (m_winner >= 0) begin
            m_waddr = (m_winner == 0) ? int'(addr0) : int'(addr1);
            m_wdata = (m_winner == 0) ? data0 : data1;
            m_wen   = !(GUARD && m_waddr == 0);
            m_pref  = 1 - m_winner;
        end else begin
            m_wen = 0;
        end
    endtask

    typedef struct {
        bit r0; int a0; logic [31:0] d0;
        bit r1; int a1; logic [31:0] d1;
        bit g0; bit g1; bit wen; int waddr; logic [31:0] wdata; int coll;
    } vec_t;

    vec_t tv [9];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        req0 = 0; req1 = 0; addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    int exp_g0_seq [4] = '{1, 0, 1, 0};
    bit pend0, pend1, eg0, eg1;
    int wait0, wait1;

    initial begin
        reset = 1'b1;
        req0 = 1; req1 = 1; addr0 = 5'd3; addr1 = 5'd4; data0 = 32'h1; data1 = 32'h2;
        @(negedge clk); @(negedge clk);
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_wen", wen, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_wdec", wdec, 0);
        chk("rst_coll", collisions, 0);
        req0 = 0; req1 = 0;
        reset = 1'b0;
        @(negedge clk);
        chk("idle_wen", wen, 0);
        chk("idle_coll", collisions, 0);

        // Table: applied in order from reset, expectations hand-derived.
        tv[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 32'h0,   1, 0, 1, 5,  32'hDEADBEEF, 0};
        tv[1] = '{1, 3, 32'h11,       1, 4, 32'h22,  0, 1, 1, 4,  32'h22,       1};
        tv[2] = '{1, 3, 32'h11,       1, 6, 32'h33,  1, 0, 1, 3,  32'h11,       2};
        tv[3] = '{1, 7, 32'h77,       1, 6, 32'h33,  0, 1, 1, 6,  32'h33,       3};
        tv[4] = '{1, 7, 32'h77,       0, 0, 32'h0,   1, 0, 1, 7,  32'h77,       3};
        tv[5] = '{0, 0, 32'h0,        1, 9, 32'h44,  0, 1, 1, 9,  32'h44,       3};
        tv[6] = '{1, 10, 32'h55,      1, 11, 32'h66, 1, 0, 1, 10, 32'h55,       4};
        tv[7] = '{0, 0, 32'h0,        0, 0, 32'h0,   0, 0, 0, 10, 32'h55,       4};
        tv[8] = '{1, 0, 32'h7,        0, 0, 32'h0,   1, 0, !GUARD, 0, 32'h7,    4};
        for (int i = 0; i < 9; i++) begin
            req0 = tv[i].r0; addr0 = tv[i].a0[AWIDTH-1:0]; data0 = tv[i].d0;
            req1 = tv[i].r1; addr1 = tv[i].a1[AWIDTH-1:0]; data1 = tv[i].d1;
            #1;
            chk($sformatf("tv%0d_gnt0", i), gnt0, tv[i].g0);
            chk($sformatf("tv%0d_gnt1", i), gnt1, tv[i].g1);
            @(posedge clk); @(negedge clk);
            chk($sformatf("tv%0d_wen", i), wen, tv[i].wen);
            chk($sformatf("tv%0d_waddr", i), waddr, tv[i].waddr);
            chk($sformatf("tv%0d_wdata", i), wdata, tv[i].wdata);
            chk($sformatf("tv%0d_wdec", i), wdec, onehot(tv[i].waddr, tv[i].wen));
            chk($sformatf("tv%0d_coll", i), collisions, tv[i].coll);
            if (i == 1) chk("bank5_z", bank[5], 32'hDEADBEEF);
        end

        // Continuous contention from reset, then saturation.
        do_reset();
        req0 = 1; req1 = 1; addr0 = 5'd1; addr1 = 5'd2; data0 = 32'hA; data1 = 32'hB;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("alt%0d_gnt0", i), gnt0, exp_g0_seq[i]);
            chk($sformatf("alt%0d_gnt1", i), gnt1, !exp_g0_seq[i]);
            @(negedge clk);
        end
        chk("alt_coll4", collisions, 4);
        repeat (300) @(negedge clk);
        chk("sat_coll", collisions, 255);

        // Asynchronous reset mid-burst, observed before the next edge.
        chk("burst_wen", wen, 1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_wen", wen, 0);
        chk("async_wdec", wdec, 0);
        chk("async_coll", collisions, 0);
        chk("async_gnt0", gnt0, 0);
        chk("async_gnt1", gnt1, 0);
        @(negedge clk);
        chk("rst_hold_gnt", {gnt0, gnt1}, 0);
        req0 = 0; req1 = 0;
        reset = 1'b0;
        model_reset();

        // Random traffic against the model; requests held until granted.
        pend0 = 0; pend1 = 0; wait0 = 0; wait1 = 0;
        for (int c = 0; c < 1000; c++) begin
            if (!pend0 && ($urandom_range(0, 2) != 0)) begin
                pend0 = 1; addr0 = $urandom_range(0, NREG - 1); data0 = $urandom;
            end
            if (!pend1 && ($urandom_range(0, 2) != 0)) begin
                pend1 = 1; addr1 = $urandom_range(0, NREG - 1); data1 = $urandom;
            end
            req0 = pend0; req1 = pend1;
            #1;
            eg0 = req0 && (!req1 || m_pref == 0);
            eg1 = req1 && (!req0 || m_pref == 1);
            chk("rnd_gnt0", gnt0, eg0);
            chk("rnd_gnt1", gnt1, eg1);
            chk("rnd_excl", gnt0 & gnt1, 0);
            wait0 = (req0 && !eg0) ? wait0 + 1 : 0;
            wait1 = (req1 && !eg1) ? wait1 + 1 : 0;
            if (wait0 >= 2 || wait1 >= 2) chk("rnd_latency", 1, 0);
            @(posedge clk);
            model_edge();
            if (m_winner == 0) pend0 = 0;
            if (m_winner == 1) pend1 = 0;
            @(negedge clk);
            chk("rnd_wen", wen, m_wen);
            chk("rnd_waddr", waddr, m_waddr);
            chk("rnd_wdata", wdata, m_wdata);
            chk("rnd_wdec", wdec, onehot(m_waddr, m_wen));
            chk("rnd_onehot", $onehot0(wdec), 1);
            chk("rnd_coll", collisions, m_coll);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
